// File: rtl/rf_hw_pkg.sv
// Shared types and helpers for the reflection variable access agent.
package rf_hw_pkg;

  // Default geometry of the agent; modules take these as parameter defaults.
  localparam int RF_NUM_VARS = 16;
  localparam int RF_DATA_W   = 32;
  localparam int RF_ID_W     = 5;

  // Widest DATA_W that rf_mask can build a mask for.
  localparam int RF_MAX_W    = 64;
  // Width field of the slot metadata; must hold $clog2(DATA_W+1) bits.
  localparam int RF_META_W   = 8;

  // Response status codes as seen by the reflection front end.
  typedef enum logic [1:0] {
    RF_OK        = 2'd0,
    RF_NO_VAR    = 2'd1,
    RF_READ_ONLY = 2'd2
  } rf_status_e;

  // Request sequencing: one request in flight at a time.
  typedef enum logic [1:0] {
    RF_IDLE   = 2'd0,
    RF_LOOKUP = 2'd1,
    RF_ACCESS = 2'd2,
    RF_RESP   = 2'd3
  } rf_state_e;

  // Per-slot metadata; width 0 means the slot is unregistered.
  typedef struct packed {
    logic [RF_META_W-1:0] width;
    logic                 ro;
  } rf_meta_t;

  // Low 'width' bits set; widths above data_w saturate to data_w.
  function automatic logic [RF_MAX_W-1:0] rf_mask(input logic [RF_META_W-1:0] width,
                                                  input int unsigned data_w);
    logic [RF_MAX_W-1:0] m;
    int unsigned         w;
    w = 32'(width);
    if (w > data_w) w = data_w;
    m = '0;
    for (int unsigned i = 0; i < RF_MAX_W; i++) m[i] = (i < w);
    return m;
  endfunction

endpackage

// File: rtl/rf_var_access_agent_if.sv
// Request/response channel between the reflection front end and the agent.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// The producer holds valid and payload stable until that edge; ready may depend on
// the consumer's state but never on valid combinationally in the same direction.
interface rf_var_access_agent_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 5
);
  import rf_hw_pkg::*;

  localparam int WIDTH_W = $clog2(DATA_W + 1);

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ID_W-1:0]     req_id;
  logic [DATA_W-1:0]   req_wdata;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W-1:0]   rsp_rdata;
  rf_status_e          rsp_status;
  logic [WIDTH_W-1:0]  rsp_width;

  // Front end side: issues requests, consumes responses.
  modport master (
    output req_valid, req_write, req_id, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_status, rsp_width
  );

  // Agent side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_write, req_id, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_status, rsp_width
  );

endinterface

// File: rtl/rf_var_meta_table.sv
// Slot metadata and value storage. Values always fit the slot's current width:
// every write (value or width change) is masked by the width in effect after the edge.
module rf_var_meta_table
  import rf_hw_pkg::*;
#(
  parameter int NUM_VARS = RF_NUM_VARS,
  parameter int DATA_W   = RF_DATA_W,
  parameter int ID_W     = RF_ID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ID_W-1:0]   cfg_id,
  input  rf_meta_t          cfg_meta,
  input  logic              val_we,
  input  logic [ID_W-1:0]   val_id,
  input  logic [DATA_W-1:0] val_wdata,
  input  logic [ID_W-1:0]   rd_id,
  output logic              rd_hit,
  output rf_meta_t          rd_meta,
  output logic [DATA_W-1:0] rd_value
);

  localparam int IDX_W = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;

  rf_meta_t            meta_q  [NUM_VARS];
  logic [DATA_W-1:0]   value_q [NUM_VARS];
  logic [NUM_VARS-1:0] cfg_sel;
  logic [NUM_VARS-1:0] val_sel;
  logic [IDX_W-1:0]    rd_idx;

  function automatic logic [DATA_W-1:0] mask_of(input rf_meta_t m);
    return DATA_W'(rf_mask(m.width, DATA_W));
  endfunction

  // Decode write targets; full-width id compare so out-of-range ids select nothing.
  always_comb begin
    cfg_sel = '0;
    val_sel = '0;
    for (int i = 0; i < NUM_VARS; i++) begin
      cfg_sel[i] = cfg_we && (cfg_id == ID_W'(i));
      val_sel[i] = val_we && (val_id == ID_W'(i));
    end
  end

  // Storage update; a width change in the same edge as a value write masks with the new width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VARS; i++) begin
        meta_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VARS; i++) begin
        if (cfg_sel[i]) begin
          meta_q[i]  <= cfg_meta;
          value_q[i] <= (val_sel[i] ? val_wdata : value_q[i]) & mask_of(cfg_meta);
        end else if (val_sel[i]) begin
          value_q[i] <= val_wdata & mask_of(meta_q[i]);
        end
      end
    end
  end

  // Combinational lookup; ids past the table read as an empty slot.
  always_comb begin
    rd_hit   = (int'(rd_id) < NUM_VARS);
    rd_idx   = rd_id[IDX_W-1:0];
    rd_meta  = '0;
    rd_value = '0;
    if (rd_hit) begin
      rd_meta  = meta_q[rd_idx];
      rd_value = value_q[rd_idx];
    end
  end

endmodule

// File: rtl/rf_var_access_agent.sv
// Serves get/set requests on the variable table: one request in flight,
// fixed IDLE -> LOOKUP -> ACCESS -> RESP sequence, response held until taken.
module rf_var_access_agent
  import rf_hw_pkg::*;
#(
  parameter int NUM_VARS = RF_NUM_VARS,
  parameter int DATA_W   = RF_DATA_W,
  parameter int ID_W     = RF_ID_W,
  localparam int WIDTH_W = $clog2(DATA_W + 1)
) (
  input  logic               clk,
  input  logic               rst,
  rf_var_access_agent_if.slave bus,
  input  logic               cfg_we,
  input  logic [ID_W-1:0]    cfg_id,
  input  logic [WIDTH_W-1:0] cfg_width,
  input  logic               cfg_ro,
  output rf_state_e          dbg_state
);

  rf_state_e          state_q, state_d;

  logic               req_write_q;
  logic [ID_W-1:0]    req_id_q;
  logic [DATA_W-1:0]  req_wdata_q;

  logic [RF_META_W-1:0] width_q;
  rf_status_e         status_q;
  rf_status_e         lookup_status;

  logic [DATA_W-1:0]  rsp_rdata_q;
  rf_status_e         rsp_status_q;
  logic [WIDTH_W-1:0] rsp_width_q;

  rf_meta_t           cfg_meta;
  logic               val_we;
  logic [DATA_W-1:0]  access_mask;
  logic [DATA_W-1:0]  set_value;
  logic               rd_hit;
  rf_meta_t           rd_meta;
  logic [DATA_W-1:0]  rd_value;

  assign cfg_meta    = '{width: RF_META_W'(cfg_width), ro: cfg_ro};
  assign access_mask = DATA_W'(rf_mask(width_q, DATA_W));
  assign set_value   = req_wdata_q & access_mask;
  assign val_we      = (state_q == RF_ACCESS) && req_write_q && (status_q == RF_OK);

  rf_var_meta_table #(
    .NUM_VARS (NUM_VARS),
    .DATA_W   (DATA_W),
    .ID_W     (ID_W)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_id    (cfg_id),
    .cfg_meta  (cfg_meta),
    .val_we    (val_we),
    .val_id    (req_id_q),
    .val_wdata (set_value),
    .rd_id     (req_id_q),
    .rd_hit    (rd_hit),
    .rd_meta   (rd_meta),
    .rd_value  (rd_value)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RF_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RF_IDLE:   if (bus.req_valid) state_d = RF_LOOKUP;
      RF_LOOKUP: state_d = RF_ACCESS;
      RF_ACCESS: state_d = RF_RESP;
      RF_RESP:   if (bus.rsp_ready) state_d = RF_IDLE;
      default:   state_d = RF_IDLE;
    endcase
  end

  // FSM-driven outputs and response payload.
  always_comb begin
    bus.req_ready  = (state_q == RF_IDLE);
    bus.rsp_valid  = (state_q == RF_RESP);
    bus.rsp_rdata  = rsp_rdata_q;
    bus.rsp_status = rsp_status_q;
    bus.rsp_width  = rsp_width_q;
    dbg_state      = state_q;
  end

  // Capture request fields on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_write_q <= 1'b0;
      req_id_q    <= '0;
      req_wdata_q <= '0;
    end else if (state_q == RF_IDLE && bus.req_valid) begin
      req_write_q <= bus.req_write;
      req_id_q    <= bus.req_id;
      req_wdata_q <= bus.req_wdata;
    end
  end

  // Classify the request against the slot metadata seen in LOOKUP.
  always_comb begin
    lookup_status = RF_OK;
    if (!rd_hit || rd_meta.width == '0)  lookup_status = RF_NO_VAR;
    else if (req_write_q && rd_meta.ro)  lookup_status = RF_READ_ONLY;
  end

  // Freeze metadata in LOOKUP so later cfg writes cannot alter the in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      width_q  <= '0;
      status_q <= RF_OK;
    end else if (state_q == RF_LOOKUP) begin
      width_q  <= rd_meta.width;
      status_q <= lookup_status;
    end
  end

  // Build the response in ACCESS; it stays put through RESP until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata_q  <= '0;
      rsp_status_q <= RF_OK;
      rsp_width_q  <= '0;
    end else if (state_q == RF_ACCESS) begin
      rsp_status_q <= status_q;
      case (status_q)
        RF_NO_VAR: begin
          rsp_rdata_q <= '0;
          rsp_width_q <= '0;
        end
        RF_READ_ONLY: begin
          rsp_rdata_q <= rd_value;
          rsp_width_q <= WIDTH_W'(width_q);
        end
        default: begin
          rsp_rdata_q <= req_write_q ? set_value : rd_value;
          rsp_width_q <= WIDTH_W'(width_q);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_var_access_agent.sv
// Directed and random get/set traffic against a table model of the variables.
module tb_rf_var_access_agent;
  import rf_hw_pkg::*;

  localparam int NV = 16;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int WW = 6;
  localparam int EW = 2 + WW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [IW-1:0] cfg_id;
  logic [WW-1:0] cfg_width;
  logic          cfg_ro;
  rf_state_e     dbg_state;

  rf_var_access_agent_if #(.DATA_W(DW), .ID_W(IW)) bus ();

  rf_var_access_agent #(.NUM_VARS(NV), .DATA_W(DW), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .cfg_we    (cfg_we),
    .cfg_id    (cfg_id),
    .cfg_width (cfg_width),
    .cfg_ro    (cfg_ro),
    .dbg_state (dbg_state)
  );

  // Clock, cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;
  int acc_cyc;

  // Reference model: what each variable holds and how it is declared.
  int unsigned   m_width [NV];
  logic          m_ro    [NV];
  logic [DW-1:0] m_val   [NV];

  // Scoreboard: {status, width, rdata} per outstanding request.
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_mask(input int unsigned w);
    logic [63:0] one;
    one = 64'd1;
    if (w >= DW) return '1;
    return DW'((one << w) - 64'd1);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_width[i] = 0;
      m_ro[i]    = 1'b0;
      m_val[i]   = '0;
    end
  endfunction

  function automatic void model_cfg(input int unsigned id, input int unsigned w, input logic ro);
    if (id >= NV) return;
    m_width[id] = w;
    m_ro[id]    = ro;
    m_val[id]   = m_val[id] & ref_mask(w);
  endfunction

  // Expected outcome of one request under the current model; applies a legal set.
  function automatic logic [EW-1:0] model_req(input logic w, input int unsigned id, input logic [DW-1:0] d);
    logic [1:0]    st;
    logic [WW-1:0] wd;
    logic [DW-1:0] rd;
    if (id >= NV || m_width[id] == 0) begin
      st = 2'd1; wd = '0; rd = '0;
    end else if (w && m_ro[id]) begin
      st = 2'd2; wd = WW'(m_width[id]); rd = m_val[id];
    end else begin
      if (w) m_val[id] = d & ref_mask(m_width[id]);
      st = 2'd0; wd = WW'(m_width[id]); rd = m_val[id];
    end
    return {st, wd, rd};
  endfunction

  // Drivers.
  task automatic do_cfg(input logic [IW-1:0] id, input logic [WW-1:0] w, input logic ro);
    @(negedge clk);
    cfg_we = 1'b1; cfg_id = id; cfg_width = w; cfg_ro = ro;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_cfg(32'(id), 32'(w), ro);
  endtask

  task automatic send(input logic w, input logic [IW-1:0] id, input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_id = id; bus.req_wdata = d;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("accept_timeout", 64'(bus.req_ready), 64'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input int hold);
    int            n;
    logic [EW-1:0] exp;
    logic [EW-1:0] snap;
    logic [EW-1:0] now;
    exp = exp_q.pop_front();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 20);
    if (!bus.rsp_valid) begin
      check({tag, " rsp_timeout"}, 64'(bus.rsp_valid), 64'd1);
      return;
    end
    check({tag, " latency"}, 64'(cyc - acc_cyc), 64'd3);
    check({tag, " status"}, 64'(bus.rsp_status), 64'(exp[EW-1 -: 2]));
    check({tag, " width"},  64'(bus.rsp_width),  64'(exp[DW +: WW]));
    check({tag, " rdata"},  64'(bus.rsp_rdata),  64'(exp[DW-1:0]));
    snap = {bus.rsp_status, bus.rsp_width, bus.rsp_rdata};
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      now = {bus.rsp_status, bus.rsp_width, bus.rsp_rdata};
      check({tag, " hold_stable"}, 64'(now), 64'(snap));
      check({tag, " hold_valid"}, 64'(bus.rsp_valid), 64'd1);
      check({tag, " hold_req_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, " rsp_drop"}, 64'(bus.rsp_valid), 64'd0);
    if (hold > 0) check({tag, " ready_after"}, 64'(bus.req_ready), 64'd1);
  endtask

  task automatic do_op(input logic w, input logic [IW-1:0] id, input logic [DW-1:0] d,
                       input string tag, input int hold);
    exp_q.push_back(model_req(w, 32'(id), d));
    send(w, id, d);
    recv(tag, hold);
  endtask

  // Directed sequence followed by random traffic.
  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_id = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    cfg_we = 1'b0; cfg_id = '0; cfg_width = '0; cfg_ro = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset req_ready",  64'(bus.req_ready),  64'd1);
    check("reset rsp_valid",  64'(bus.rsp_valid),  64'd0);
    check("reset rsp_rdata",  64'(bus.rsp_rdata),  64'd0);
    check("reset rsp_status", 64'(bus.rsp_status), 64'd0);
    check("reset rsp_width",  64'(bus.rsp_width),  64'd0);
    check("reset state",      64'(dbg_state),      64'(RF_IDLE));
    rst = 1'b0;

    do_cfg(5'd3, 6'd8, 1'b0);
    do_op(1'b1, 5'd3, 32'h1FF, "set3", 0);
    do_op(1'b0, 5'd3, 32'h0, "get3", 0);
    do_op(1'b0, 5'd7, 32'h0, "get7_novar", 0);
    do_cfg(5'd5, 6'd16, 1'b1);
    do_op(1'b1, 5'd5, 32'hABCD, "set5_ro", 0);
    do_op(1'b0, 5'd5, 32'h0, "get5", 0);
    do_op(1'b0, 5'd20, 32'h0, "get20_range", 0);
    do_op(1'b0, 5'd3, 32'h0, "get3_hold", 5);
    do_op(1'b0, 5'd3, 32'h0, "after_hold", 0);

    // Width change lands while the set is in LOOKUP.
    exp_q.push_back(model_req(1'b1, 3, 32'h12));
    send(1'b1, 5'd3, 32'h12);
    do_cfg(5'd3, 6'd4, 1'b0);
    recv("inflight_set3", 0);
    do_op(1'b0, 5'd3, 32'h0, "get3_remask", 0);

    // Clamp case: width beyond DATA_W keeps every bit.
    do_cfg(5'd9, 6'd40, 1'b0);
    do_op(1'b1, 5'd9, 32'hDEAD_BEEF, "set9_wide", 0);

    for (int i = 0; i < NV; i++)
      do_cfg(IW'(i), WW'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 4) == 0)
        do_cfg(IW'($urandom_range(0, 19)), WW'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
      else
        do_op(1'($urandom_range(0, 1)), IW'($urandom_range(0, 19)), $urandom, "rand",
              int'($urandom_range(0, 2)));
    end

    // Reset while a request sits in ACCESS.
    do_cfg(5'd3, 6'd8, 1'b0);
    send(1'b1, 5'd3, 32'h55);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst req_ready", 64'(bus.req_ready), 64'd1);
    check("midrst state",     64'(dbg_state),     64'(RF_IDLE));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst no_rsp", 64'(bus.rsp_valid), 64'd0);
    do_op(1'b0, 5'd3, 32'h0, "get3_after_rst", 0);
    do_op(1'b0, 5'd5, 32'h0, "get5_after_rst", 0);
    do_op(1'b0, 5'd9, 32'h0, "get9_after_rst", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
